// File: rtl/input_conditioner_pkg.sv
// Shared types and helpers for the board input conditioner.
package input_cond_pkg;

  // Key repeat FSM encodings, kept as plain constants for legacy users.
  localparam logic [1:0] KS_IDLE   = 2'd0;
  localparam logic [1:0] KS_HOLD   = 2'd1;
  localparam logic [1:0] KS_REPEAT = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = KS_IDLE,
    HOLD   = KS_HOLD,
    REPEAT = KS_REPEAT
  } key_state_e;

  // Bits needed to hold values 0..max_count (never less than one bit).
  function automatic int cnt_width(input int max_count);
    if (max_count < 1) begin
      return 1;
    end else begin
      return $clog2(max_count + 1);
    end
  endfunction

  // Larger of two integers, used to size the shared repeat counter.
  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Pin-side and PIO-side signals of the input conditioner.
interface input_conditioner_if #(
  parameter int NUM_KEYS = 4,
  parameter int NUM_SW   = 10
);
  logic [NUM_KEYS-1:0] KEY;
  logic [NUM_SW-1:0]   SW;
  logic [NUM_KEYS-1:0] key_db;
  logic [NUM_SW-1:0]   sw_db;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic                sw_change;

  // Board side: drives raw pins, consumes clean levels and strobes.
  modport master (
    output KEY, SW,
    input  key_db, sw_db, key_press, key_release, sw_change
  );

  // Conditioner side.
  modport slave (
    input  KEY, SW,
    output key_db, sw_db, key_press, key_release, sw_change
  );
endinterface

// File: rtl/input_conditioner_debounce_chan.sv
// One input channel: 2-flop synchroniser, stability counter and accepted level.
module debounce_chan
  import input_cond_pkg::*;
#(
  parameter logic RESET_LEVEL     = 1'b0,
  parameter int   DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_stable
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;

  // Bring the asynchronous pin into the clock domain; idle level on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= RESET_LEVEL;
      r_sync2 <= RESET_LEVEL;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Count consecutive mismatch cycles; any agreement restarts the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= RESET_LEVEL;
      r_cnt    <= {CW{1'b0}};
    end else if (r_sync2 == r_stable) begin
      r_cnt    <= {CW{1'b0}};
    end else if (r_cnt == CNT_LAST) begin
      r_stable <= r_sync2;
      r_cnt    <= {CW{1'b0}};
    end else begin
      r_cnt    <= r_cnt + CW'(1);
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/input_conditioner.sv
// Debounces DE1 keys/switches and derives press, release and repeat strobes.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int NUM_KEYS             = 4,
  parameter int NUM_SW               = 10,
  parameter int DEBOUNCE_CYCLES      = 500000,
  parameter int REPEAT_DELAY_CYCLES  = 25000000,
  parameter int REPEAT_PERIOD_CYCLES = 5000000
) (
  input logic                CLOCK_50,
  input logic                reset_n,
  input_conditioner_if.slave bus
);

  localparam int            RW          = cnt_width(max_int(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES));
  localparam bit            REPEAT_EN   = (REPEAT_DELAY_CYCLES != 0);
  localparam logic [RW-1:0] DELAY_LAST  = RW'((REPEAT_DELAY_CYCLES > 0) ? REPEAT_DELAY_CYCLES - 1 : 0);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD_CYCLES - 1);

  logic [NUM_KEYS-1:0] w_key_db;
  logic [NUM_SW-1:0]   w_sw_db;
  logic [NUM_KEYS-1:0] w_key_fall;
  logic [NUM_KEYS-1:0] w_key_rise;
  logic [NUM_KEYS-1:0] w_key_press;

  logic [NUM_KEYS-1:0] r_key_prev;
  logic [NUM_KEYS-1:0] r_key_rel;
  logic [NUM_SW-1:0]   r_sw_prev;
  logic                r_sw_chg;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key_db
    debounce_chan #(
      .RESET_LEVEL     (1'b1),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan (
      .clk      (CLOCK_50),
      .rst_n    (reset_n),
      .i_raw    (bus.KEY[k]),
      .o_stable (w_key_db[k])
    );
  end

  for (genvar s = 0; s < NUM_SW; s++) begin : g_sw_db
    debounce_chan #(
      .RESET_LEVEL     (1'b0),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan (
      .clk      (CLOCK_50),
      .rst_n    (reset_n),
      .i_raw    (bus.SW[s]),
      .o_stable (w_sw_db[s])
    );
  end

  // Keys are active-low: a press is a falling edge of the debounced level.
  assign w_key_fall = r_key_prev & ~w_key_db;
  assign w_key_rise = w_key_db & ~r_key_prev;

  // Previous-cycle copies of the clean levels and the edge strobes derived from them.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_key_prev <= {NUM_KEYS{1'b1}};
      r_key_rel  <= {NUM_KEYS{1'b0}};
      r_sw_prev  <= {NUM_SW{1'b0}};
      r_sw_chg   <= 1'b0;
    end else begin
      r_key_prev <= w_key_db;
      r_key_rel  <= w_key_rise;
      r_sw_prev  <= w_sw_db;
      r_sw_chg   <= |(w_sw_db ^ r_sw_prev);
    end
  end

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_rpt
    key_state_e    r_state;
    key_state_e    w_state_nxt;
    logic [RW-1:0] r_rcnt;
    logic [RW-1:0] w_rcnt_nxt;
    logic          r_press;
    logic          w_press_nxt;

    // Next-state logic; a release always wins over a repeat expiring together.
    always_comb begin
      w_state_nxt = r_state;
      w_rcnt_nxt  = r_rcnt;
      w_press_nxt = 1'b0;
      case (r_state)
        IDLE: begin
          w_rcnt_nxt = {RW{1'b0}};
          if (w_key_fall[g]) begin
            w_press_nxt = 1'b1;
            w_state_nxt = HOLD;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        HOLD: begin
          if (w_key_rise[g]) begin
            w_state_nxt = IDLE;
            w_rcnt_nxt  = {RW{1'b0}};
          end else if (!REPEAT_EN) begin
            w_rcnt_nxt  = {RW{1'b0}};
          end else if (r_rcnt == DELAY_LAST) begin
            w_press_nxt = 1'b1;
            w_rcnt_nxt  = {RW{1'b0}};
            w_state_nxt = REPEAT;
          end else begin
            w_rcnt_nxt  = r_rcnt + RW'(1);
          end
        end
        REPEAT: begin
          if (w_key_rise[g]) begin
            w_state_nxt = IDLE;
            w_rcnt_nxt  = {RW{1'b0}};
          end else if (r_rcnt == PERIOD_LAST) begin
            w_press_nxt = 1'b1;
            w_rcnt_nxt  = {RW{1'b0}};
          end else begin
            w_rcnt_nxt  = r_rcnt + RW'(1);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_rcnt_nxt  = {RW{1'b0}};
        end
      endcase
    end

    // Repeat FSM state, counter and registered press strobe.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
        r_state <= IDLE;
        r_rcnt  <= {RW{1'b0}};
        r_press <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_rcnt  <= w_rcnt_nxt;
        r_press <= w_press_nxt;
      end
    end

    assign w_key_press[g] = r_press;
  end

  assign bus.key_db      = w_key_db;
  assign bus.sw_db       = w_sw_db;
  assign bus.key_press   = w_key_press;
  assign bus.key_release = r_key_rel;
  assign bus.sw_change   = r_sw_chg;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench: vector table, directed corner sequences, random soak vs reference model.
module tb_input_conditioner;

  localparam int NK = 4;
  localparam int NS = 10;
  localparam int DB = 8;
  localparam int RD = 20;
  localparam int RP = 5;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NK-1:0] key_r;
  logic [NS-1:0] sw_r;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  input_conditioner_if #(.NUM_KEYS(NK), .NUM_SW(NS)) bus ();
  assign bus.KEY = key_r;
  assign bus.SW  = sw_r;

  input_conditioner #(
    .NUM_KEYS             (NK),
    .NUM_SW               (NS),
    .DEBOUNCE_CYCLES      (DB),
    .REPEAT_DELAY_CYCLES  (RD),
    .REPEAT_PERIOD_CYCLES (RP)
  ) dut (
    .CLOCK_50 (clk),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  // ---------------- reference model ----------------
  // Raw-sample history per channel: bit j is the value sampled j edges ago.
  logic [DB+1:0] hk [NK];
  logic [DB+1:0] hs [NS];
  logic [NK-1:0] m_kdb, m_kdb_p;
  logic [NS-1:0] m_sdb, m_sdb_p;
  int            m_pe [NK];
  int            m_cyc;

  task automatic model_reset();
    for (int i = 0; i < NK; i++) begin
      hk[i]   = {(DB+2){1'b1}};
      m_pe[i] = 0;
    end
    for (int i = 0; i < NS; i++) hs[i] = {(DB+2){1'b0}};
    m_kdb = '1; m_kdb_p = '1;
    m_sdb = '0; m_sdb_p = '0;
    m_cyc = 0;
  endtask

  // Advance one clock edge; returns the outputs expected right after it.
  task automatic model_edge(output logic [22:0] exp);
    logic [NK-1:0] ep, er;
    logic ec;
    m_cyc++;
    for (int i = 0; i < NK; i++) begin
      ep[i] = 1'b0;
      er[i] = m_kdb[i] & ~m_kdb_p[i];
      if (!m_kdb[i]) begin
        if (m_kdb_p[i]) begin
          ep[i]   = 1'b1;
          m_pe[i] = m_cyc;
        end else begin
          int t;
          t = m_cyc - m_pe[i];
          if (t >= RD && ((t - RD) % RP) == 0) ep[i] = 1'b1;
        end
      end
    end
    ec = (m_sdb != m_sdb_p);
    m_kdb_p = m_kdb;
    m_sdb_p = m_sdb;
    // Accept a new level once the last DB synchronised samples all disagree with it.
    for (int i = 0; i < NK; i++) begin
      hk[i] = {hk[i][DB:0], key_r[i]};
      if (hk[i][DB+1:2] == {DB{~m_kdb[i]}}) m_kdb[i] = ~m_kdb[i];
    end
    for (int i = 0; i < NS; i++) begin
      hs[i] = {hs[i][DB:0], sw_r[i]};
      if (hs[i][DB+1:2] == {DB{~m_sdb[i]}}) m_sdb[i] = ~m_sdb[i];
    end
    exp = {m_kdb, m_sdb, ep, er, ec};
  endtask

  // ---------------- checking helpers ----------------
  function automatic logic [22:0] outs();
    return {bus.key_db, bus.sw_db, bus.key_press, bus.key_release, bus.sw_change};
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model, then compare every output just after the edge.
  task automatic step();
    logic [22:0] e;
    @(posedge clk);
    model_edge(e);
    #1;
    check32("model", 32'(outs()), 32'(e));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Press key ch, keep it held 'hold' cycles past acceptance, release and watch strobes.
  task automatic hold_test(input string name, input int ch, input int hold,
                           input int exp_np, input int exp_rel_edge);
    int np, nr, re;
    np = 0; nr = 0; re = -1;
    key_r[ch] = 1'b0;
    for (int e = 1; e <= DB + 2 + hold; e++) begin
      step();
      if (bus.key_press[ch]) np++;
      if (e == DB + 2) check1({name, "_db"}, bus.key_db[ch], 1'b0);
    end
    key_r[ch] = 1'b1;
    for (int e = DB + 3 + hold; e <= DB + 32 + hold; e++) begin
      step();
      if (bus.key_press[ch]) np++;
      if (bus.key_release[ch]) begin
        nr++;
        re = e;
      end
    end
    check32({name, "_presses"}, 32'(np), 32'(exp_np));
    check32({name, "_releases"}, 32'(nr), 32'd1);
    check32({name, "_rel_edge"}, 32'(re), 32'(exp_rel_edge));
  endtask

  typedef struct {
    logic [NK-1:0] key;
    logic [NS-1:0] sw;
    int            cycles;
    logic [NK-1:0] exp_key;
    logic [NS-1:0] exp_sw;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{4'hF, 10'h000, 12, 4'hF, 10'h000};
    vecs[1] = '{4'hE, 10'h201, 12, 4'hE, 10'h201};
    vecs[2] = '{4'hE, 10'h201, 30, 4'hE, 10'h201};
    vecs[3] = '{4'hF, 10'h000, 12, 4'hF, 10'h000};
    vecs[4] = '{4'h0, 10'h3FF, 12, 4'h0, 10'h3FF};
    vecs[5] = '{4'hF, 10'h3FF,  5, 4'h0, 10'h3FF};
    vecs[6] = '{4'hF, 10'h3FF, 10, 4'hF, 10'h3FF};
    vecs[7] = '{4'hF, 10'h000, 12, 4'hF, 10'h000};

    key_r = 4'hF;
    sw_r  = 10'h000;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check32("reset_values", 32'(outs()), 32'({4'hF, 10'h000, 4'h0, 4'h0, 1'b0}));
    @(negedge clk);
    reset_n = 1'b1;

    // Table-driven levels.
    for (int v = 0; v < 8; v++) begin
      key_r = vecs[v].key;
      sw_r  = vecs[v].sw;
      idle(vecs[v].cycles);
      check32($sformatf("vec%0d_key_db", v), 32'(bus.key_db), 32'(vecs[v].exp_key));
      check32($sformatf("vec%0d_sw_db", v), 32'(bus.sw_db), 32'(vecs[v].exp_sw));
    end
    idle(3);

    // Clean press: accepted at edge 10, strobe at 11, first repeat at 31.
    key_r[0] = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      step();
      check1("clean_db", bus.key_db[0], (e >= 10) ? 1'b0 : 1'b1);
      check1("clean_press", bus.key_press[0], (e == 11 || e == 31) ? 1'b1 : 1'b0);
    end
    key_r[0] = 1'b1;
    idle(30);

    // Bounce on KEY[1]: runs of 3 never reach the 8-cycle window.
    for (int e = 0; e < 42; e++) begin
      key_r[1] = (e < 30 && ((e / 3) % 2) == 0) ? 1'b0 : 1'b1;
      step();
      check1("bounce_db", bus.key_db[1], 1'b1);
      check1("bounce_press", bus.key_press[1], 1'b0);
      check1("bounce_rel", bus.key_release[1], 1'b0);
    end
    idle(5);

    // Hold-to-repeat: presses at 11, 31, 36 .. 81; release accepted at 82, strobe at 83.
    hold_test("hold", 2, 62, 12, 83);
    // Release strobe lands exactly where a repeat would have expired (edge 81).
    hold_test("collide", 2, 60, 11, 81);
    // FSM must be back in IDLE: a fresh press gives the initial strobe again.
    hold_test("after_collide", 2, 15, 2, 36);
    idle(5);

    // Switches change together: one sw_change strobe.
    sw_r = 10'h201;
    for (int e = 1; e <= 20; e++) begin
      step();
      check32("sw_db", 32'(bus.sw_db), (e >= 10) ? 32'h201 : 32'h000);
      check1("sw_change", bus.sw_change, (e == 11) ? 1'b1 : 1'b0);
    end
    sw_r = 10'h000;
    idle(15);

    // Reset while KEY[0] repeats and a switch counter sits at 5.
    key_r[0] = 1'b0;
    idle(35);
    sw_r[3] = 1'b1;
    idle(7);
    #2;
    reset_n = 1'b0;
    #1;
    check32("reset_async", 32'(outs()), 32'({4'hF, 10'h000, 4'h0, 4'h0, 1'b0}));
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check32("reset_hold", 32'(outs()), 32'({4'hF, 10'h000, 4'h0, 4'h0, 1'b0}));
    @(negedge clk);
    reset_n = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      step();
      check1("rst_exit_press", bus.key_press[0], (e == 11) ? 1'b1 : 1'b0);
      check1("rst_exit_swchg", bus.sw_change, (e == 11) ? 1'b1 : 1'b0);
    end
    key_r = 4'hF;
    sw_r  = 10'h000;
    idle(40);

    // Random soak against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NK; i++)
        if ($urandom_range(0, 59) == 0) key_r[i] = ~key_r[i];
      for (int i = 0; i < NS; i++)
        if ($urandom_range(0, 19) == 0) sw_r[i] = ~sw_r[i];
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Board-input front end between the DE1 pins (KEY, SW) and the Nios II system's buttons/switches PIOs. It synchronises every raw input to CLOCK_50 and debounces it with a per-channel stability counter. It drives clean levels to the PIOs. For the keys it also produces one-cycle press/release strobes and hold-to-repeat press strobes for hardware consumers such as GPIO logic and LED test paths.

## Interface
- NUM_KEYS, 4: key channels; raw keys are active-low.
- NUM_SW, 10: switch channels; active-high.
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a new level (10 ms at 50 MHz). Minimum 1.
- REPEAT_DELAY_CYCLES, 25000000: hold time after a press before the first repeat strobe (0.5 s).
- REPEAT_PERIOD_CYCLES, 5000000: interval between repeat strobes (0.1 s). Minimum 1.
- CLOCK_50  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- KEY  in  NUM_KEYS  raw push-buttons, 0 = pressed.
- SW  in  NUM_SW  raw slide switches.
- key_db  out  NUM_KEYS  debounced keys, active-low, to buttons PIO. Reset: all 1.
- sw_db  out  NUM_SW  debounced switches, to switches PIO. Reset: all 0.
- key_press  out  NUM_KEYS  one-cycle strobe on accepted press and on each repeat. Reset: 0.
- key_release  out  NUM_KEYS  one-cycle strobe on accepted release. Reset: 0.
- sw_change  out  1  one-cycle strobe when any sw_db bit changed this cycle. Reset: 0.

## Operation
- Per channel: 2-flop synchroniser → sync. Sync flops reset to the idle level: 1 for keys, 0 for switches.
- Per-channel counter cnt, width $clog2(DEBOUNCE_CYCLES+1). It runs only while sync ≠ stable; cnt clears to 0 on any cycle where sync == stable.
- When sync ≠ stable and cnt == DEBOUNCE_CYCLES−1: stable ← sync and cnt ← 0. A new level is therefore accepted after exactly DEBOUNCE_CYCLES consecutive mismatch cycles.
- A bounce (sync returns to stable before the count completes) restarts the window and produces no output change.
- key_db = stable (keys); sw_db = stable (switches). key_press and key_release are the registered falling and rising edges of key_db.
- sw_change = OR of the per-bit XOR of sw_db against its value on the previous cycle.
- Per-key repeat FSM with states IDLE, HOLD, REPEAT, and a repeat counter rcnt sized for max(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES):
  - IDLE: on an accepted press, pulse key_press, rcnt ← 0, go to HOLD.
  - HOLD: rcnt increments. When rcnt == REPEAT_DELAY_CYCLES−1, pulse key_press, rcnt ← 0, go to REPEAT.
  - REPEAT: rcnt increments. When rcnt == REPEAT_PERIOD_CYCLES−1, pulse key_press and rcnt ← 0.
  - HOLD or REPEAT: an accepted release pulses key_release and returns to IDLE. Release takes priority over a repeat expiring in the same cycle, so no key_press is issued.
- REPEAT_DELAY_CYCLES == 0 disables repeat: the FSM goes IDLE → HOLD and stays in HOLD until release.
- Channels are independent. Simultaneous events on different channels all strobe in the same cycle.

## Timing
- Raw edge to debounced level change: 2 sync cycles + DEBOUNCE_CYCLES cycles.
- key_press, key_release and sw_change assert 1 cycle after the matching key_db/sw_db change, for exactly 1 cycle.
- First repeat strobe: REPEAT_DELAY_CYCLES cycles after the initial key_press. Later strobes follow every REPEAT_PERIOD_CYCLES cycles.
- Reset asserted at any point, including mid-count or in REPEAT: all state returns immediately to reset values. No strobe is emitted on reset entry or on reset exit.
- After reset deassertion, an input held at its non-idle level is accepted after 2 + DEBOUNCE_CYCLES cycles, with normal strobes.

## Structure
- Package input_cond_pkg: key FSM enum (IDLE, HOLD, REPEAT) and a counter-width helper function.
- Sub-module debounce_chan, parameterised by reset level and DEBOUNCE_CYCLES, containing synchroniser + counter + stable register. Instantiated NUM_KEYS + NUM_SW times.
- The top-level holds the edge registers, sw_change, and a generate loop of repeat FSMs.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=8, REPEAT_DELAY_CYCLES=20, REPEAT_PERIOD_CYCLES=5.
- Clean press: KEY[0] 1→0 held → key_db[0]=0 at cycle 10, key_press[0] pulse at cycle 11, no further pulses before cycle 31.
- Bounce: KEY[1] toggles every 3 cycles for 30 cycles, then rests at 1 → key_db[1] stays 1, no strobes.
- Hold repeat: hold KEY[2] for 60 cycles after acceptance → key_press[2] pulses at +1, +21, +26, +31, … On release, one key_release[2] pulse after 10 cycles and no further key_press.
- Release vs repeat: release accepted on the same cycle a repeat expires → key_release only, FSM in IDLE.
- Switches: SW=10'h000→10'h201 simultaneously → sw_db=10'h201 at cycle 10, exactly one sw_change pulse.
- Reset mid-operation: assert reset_n=0 during REPEAT with cnt=5 → outputs return to reset values immediately. After release with KEY[0] held low → key_press[0] pulses once, 11 cycles after deassertion.
